// File: rtl/mipi_phy_ser_ctrl.sv
// mipi_phy_ser_ctrl: D-PHY transmit lane sequencer (byte clock).
// Ports: clk/resetb, lane count, din stream in; hs/lp lane drive out.
module mipi_phy_ser_ctrl #(
  parameter int MAX_LANES    = 1,
  parameter int LPX_CYC      = 8,
  parameter int HS_PREP_CYC  = 4,
  parameter int HS_ZERO_CYC  = 16,
  parameter int HS_TRAIL_CYC = 8,
  parameter int EXIT_CYC     = 16
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic [2:0]             num_active_lanes,
  input  logic [MAX_LANES-1:0]   md_polarity,
  input  logic [8*MAX_LANES-1:0] din,
  input  logic                   din_valid,
  input  logic                   din_last,
  input  logic [MAX_LANES-1:0]   din_keep,
  output logic                   din_ready,
  output logic [8*MAX_LANES-1:0] hs_data,
  output logic [MAX_LANES-1:0]   hs_oe,
  output logic [MAX_LANES-1:0]   lp_p,
  output logic [MAX_LANES-1:0]   lp_n,
  output logic                   busy,
  output logic                   underflow
);

  localparam int CW = 16;
  localparam int W  = 8 * MAX_LANES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LPX,
    ST_PREP,
    ST_ZERO,
    ST_SYNC,
    ST_DATA,
    ST_TRAIL,
    ST_EXIT
  } state_t;

  state_t               state;
  state_t               nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [MAX_LANES-1:0] lane_en;
  logic [MAX_LANES-1:0] en_nxt;
  logic [MAX_LANES-1:0] last_bit;
  logic [MAX_LANES-1:0] lb_nxt;
  logic [MAX_LANES-1:0] keep_eff;
  logic [MAX_LANES-1:0] oe_nxt;
  logic [MAX_LANES-1:0] lpp_nxt;
  logic [MAX_LANES-1:0] lpn_nxt;
  logic [W-1:0]         hs_nxt;
  logic [7:0]           lane_byte [MAX_LANES];
  logic                 uf_nxt;
  logic                 accept;
  logic [2:0]           n_sel;

  function automatic logic [MAX_LANES-1:0]
    lane_mask(input logic [2:0] n);
    for (int i = 0; i < MAX_LANES; i++)
      lane_mask[i] = (i < int'(n));
  endfunction

  assign din_ready = (state == ST_SYNC) ||
                     (state == ST_DATA);
  assign accept    = din_valid & din_ready;

  always_comb begin
    n_sel = num_active_lanes;
    if (num_active_lanes == 3'd0 ||
        int'(num_active_lanes) > MAX_LANES)
      n_sel = 3'd1;
    en_nxt = lane_en;
    if (state == ST_IDLE)
      en_nxt = lane_mask(n_sel);
    keep_eff = din_last ? din_keep : '1;
    keep_eff[0] = 1'b1;
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    uf_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (din_valid) begin
          nxt     = ST_LPX;
          cnt_nxt = CW'(LPX_CYC - 1);
        end
      end
      ST_LPX: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0) begin
          nxt     = ST_PREP;
          cnt_nxt = CW'(HS_PREP_CYC - 1);
        end
      end
      ST_PREP: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0) begin
          nxt     = ST_ZERO;
          cnt_nxt = CW'(HS_ZERO_CYC - 1);
        end
      end
      ST_ZERO: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0)
          nxt = ST_SYNC;
      end
      ST_SYNC, ST_DATA: begin
        if (!din_valid) begin
          nxt     = ST_TRAIL;
          cnt_nxt = CW'(HS_TRAIL_CYC - 1);
          uf_nxt  = 1'b1;
        end else if (din_last) begin
          // one extra count: first cycle carries the final byte
          nxt     = ST_TRAIL;
          cnt_nxt = CW'(HS_TRAIL_CYC);
        end else begin
          nxt = ST_DATA;
        end
      end
      ST_TRAIL: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0) begin
          nxt     = ST_EXIT;
          cnt_nxt = CW'(EXIT_CYC - 1);
        end
      end
      ST_EXIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0)
          nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    lb_nxt  = last_bit;
    oe_nxt  = '0;
    lpp_nxt = '1;
    lpn_nxt = '1;
    hs_nxt  = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      lane_byte[i] = 8'h00;
      unique case (nxt)
        ST_SYNC: begin
          lane_byte[i] = 8'hB8;
          lb_nxt[i]    = 1'b0;
        end
        ST_DATA, ST_TRAIL: begin
          if (accept && keep_eff[i]) begin
            lane_byte[i] = din[8*i+:8];
            lb_nxt[i]    = din[8*i];
          end else begin
            lane_byte[i] = {8{~last_bit[i]}};
          end
        end
        default: lane_byte[i] = 8'h00;
      endcase
      oe_nxt[i] = en_nxt[i] &
        (nxt inside {ST_ZERO, ST_SYNC,
                     ST_DATA, ST_TRAIL});
      lpp_nxt[i] = ~en_nxt[i] |
        (nxt inside {ST_IDLE, ST_EXIT});
      lpn_nxt[i] = ~en_nxt[i] |
        (nxt inside {ST_IDLE, ST_LPX, ST_EXIT});
      if (oe_nxt[i])
        hs_nxt[8*i+:8] = lane_byte[i] ^
                         {8{md_polarity[i]}};
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      lane_en   <= '0;
      last_bit  <= '0;
      hs_data   <= '0;
      hs_oe     <= '0;
      lp_p      <= '1;
      lp_n      <= '1;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      lane_en   <= en_nxt;
      last_bit  <= lb_nxt;
      hs_data   <= hs_nxt;
      hs_oe     <= oe_nxt;
      lp_p      <= lpp_nxt;
      lp_n      <= lpn_nxt;
      busy      <= (nxt != ST_IDLE);
      underflow <= uf_nxt;
    end
  end

endmodule

// File: tb/tb_mipi_phy_ser_ctrl.sv
// tb_mipi_phy_ser_ctrl: vector table + reset sequence
// for the D-PHY lane sequencer, 4-lane build.
module tb_mipi_phy_ser_ctrl;

  logic        clk;
  logic        resetb;
  logic [2:0]  num_active_lanes;
  logic [3:0]  md_polarity;
  logic [31:0] din;
  logic        din_valid;
  logic        din_last;
  logic [3:0]  din_keep;
  logic        din_ready;
  logic [31:0] hs_data;
  logic [3:0]  hs_oe;
  logic [3:0]  lp_p;
  logic [3:0]  lp_n;
  logic        busy;
  logic        underflow;

  int n_chk;
  int n_fail;

  mipi_phy_ser_ctrl #(.MAX_LANES(4)) dut (
    .clk              (clk),
    .resetb           (resetb),
    .num_active_lanes (num_active_lanes),
    .md_polarity      (md_polarity),
    .din              (din),
    .din_valid        (din_valid),
    .din_last         (din_last),
    .din_keep         (din_keep),
    .din_ready        (din_ready),
    .hs_data          (hs_data),
    .hs_oe            (hs_oe),
    .lp_p             (lp_p),
    .lp_n             (lp_n),
    .busy             (busy),
    .underflow        (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          reps;
    logic [2:0]  n;
    logic [3:0]  p;
    logic        v;
    logic        l;
    logic [3:0]  k;
    logic [31:0] d;
    logic [46:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input string nm, input int r,
    input logic [2:0] n, input logic [3:0] p,
    input logic v, input logic l,
    input logic [3:0] k, input logic [31:0] d,
    input logic [31:0] hs, input logic [3:0] oe,
    input logic [3:0] lpp, input logic [3:0] lpn,
    input logic bz, input logic rd, input logic uf);
    vec_t e;
    e.name = nm; e.reps = r; e.n = n; e.p = p;
    e.v = v; e.l = l; e.k = k; e.d = d;
    e.exp = {hs, oe, lpp, lpn, bz, rd, uf};
    vq.push_back(e);
  endtask

  task automatic pre(
    input logic [2:0] n, input logic [2:0] n2,
    input logic [3:0] p, input logic [31:0] d,
    input logic l, input logic [3:0] k,
    input logic [3:0] m, input logic [31:0] zhs);
    add("idle_go", 1, n, p, 1, l, k, d,
        0, 0, 4'hF, 4'hF, 0, 0, 0);
    add("lpx", 8, n2, p, 1, l, k, d,
        0, 0, ~m, 4'hF, 1, 0, 0);
    add("prep", 4, n2, p, 1, l, k, d,
        0, 0, ~m, ~m, 1, 0, 0);
    add("zero", 16, n2, p, 1, l, k, d,
        zhs, m, ~m, ~m, 1, 0, 0);
  endtask

  task automatic post(input logic [3:0] p);
    add("exit", 16, 1, p, 0, 0, 4'hF, 0,
        0, 0, 4'hF, 4'hF, 1, 0, 0);
    add("idle", 1, 1, p, 0, 0, 4'hF, 0,
        0, 0, 4'hF, 4'hF, 0, 0, 0);
  endtask

  task automatic pkt1(input logic [2:0] n);
    pre(n, n, 0, 32'h5A5A5AAA, 0, 4'hF, 4'h1, 0);
    add("sync", 1, n, 0, 1, 0, 4'hF, 32'h5A5A5AAA,
        32'h000000B8, 1, 4'hE, 4'hE, 1, 1, 0);
    add("d0", 1, n, 0, 1, 0, 4'hF, 32'h5A5A5A55,
        32'h000000AA, 1, 4'hE, 4'hE, 1, 1, 0);
    add("d1", 1, n, 0, 1, 1, 4'hF, 32'h5A5A5A0F,
        32'h00000055, 1, 4'hE, 4'hE, 1, 1, 0);
    add("dlast", 1, n, 0, 0, 0, 4'hF, 0,
        32'h0000000F, 1, 4'hE, 4'hE, 1, 0, 0);
    add("trail", 8, n, 0, 0, 0, 4'hF, 0,
        32'h00000000, 1, 4'hE, 4'hE, 1, 0, 0);
    post(0);
  endtask

  task automatic check(
    input string nm, input logic [46:0] exp);
    logic [46:0] got;
    got = {hs_data, hs_oe, lp_p, lp_n,
           busy, din_ready, underflow};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t e);
    num_active_lanes = e.n;
    md_polarity      = e.p;
    din_valid        = e.v;
    din_last         = e.l;
    din_keep         = e.k;
    din              = e.d;
  endtask

  initial begin
    int t;
    n_chk = 0;
    n_fail = 0;
    resetb = 1'b0;
    num_active_lanes = 3'd1;
    md_polarity = '0;
    din = '0;
    din_valid = 1'b0;
    din_last = 1'b0;
    din_keep = '1;

    pkt1(3'd1);
    pkt1(3'd0);
    pkt1(3'd5);
    // 4 lanes, keep only lanes 0/1 on the single beat
    pre(4, 4, 0, 32'h44332211, 1, 4'h3, 4'hF, 0);
    add("s2_sync", 1, 4, 0, 1, 1, 4'h3, 32'h44332211,
        32'hB8B8B8B8, 4'hF, 0, 0, 1, 1, 0);
    add("s2_last", 1, 4, 0, 0, 0, 4'hF, 0,
        32'hFFFF2211, 4'hF, 0, 0, 1, 0, 0);
    add("s2_trail", 8, 4, 0, 0, 0, 4'hF, 0,
        32'hFFFFFF00, 4'hF, 0, 0, 1, 0, 0);
    post(0);
    // N=2, lane count change after start ignored
    pre(2, 4, 0, 32'h99887766, 1, 4'hF, 4'h3, 0);
    add("s3_sync", 1, 4, 0, 1, 1, 4'hF, 32'h99887766,
        32'h0000B8B8, 4'h3, 4'hC, 4'hC, 1, 1, 0);
    add("s3_last", 1, 4, 0, 0, 0, 4'hF, 0,
        32'h00007766, 4'h3, 4'hC, 4'hC, 1, 0, 0);
    add("s3_trail", 8, 4, 0, 0, 0, 4'hF, 0,
        32'h000000FF, 4'h3, 4'hC, 4'hC, 1, 0, 0);
    post(0);
    // valid drops mid-packet (last high with it)
    pre(1, 1, 0, 32'h12, 0, 4'hF, 4'h1, 0);
    add("s4_sync", 1, 1, 0, 1, 0, 4'hF, 32'h12,
        32'hB8, 1, 4'hE, 4'hE, 1, 1, 0);
    add("s4_d0", 1, 1, 0, 1, 0, 4'hF, 32'h34,
        32'h12, 1, 4'hE, 4'hE, 1, 1, 0);
    add("s4_drop", 1, 1, 0, 0, 1, 4'hF, 32'h56,
        32'h34, 1, 4'hE, 4'hE, 1, 1, 0);
    add("s4_uf", 1, 1, 0, 0, 0, 4'hF, 0,
        32'hFF, 1, 4'hE, 4'hE, 1, 0, 1);
    add("s4_trail", 7, 1, 0, 0, 0, 4'hF, 0,
        32'hFF, 1, 4'hE, 4'hE, 1, 0, 0);
    post(0);
    // lane 0 inverted, keep[0]=0 still sends byte
    pre(1, 1, 4'h5, 32'hAA, 1, 4'h0, 4'h1, 32'hFF);
    add("s5_sync", 1, 1, 4'h5, 1, 1, 4'h0, 32'hAA,
        32'h47, 1, 4'hE, 4'hE, 1, 1, 0);
    add("s5_last", 1, 1, 4'h5, 0, 0, 4'hF, 0,
        32'h55, 1, 4'hE, 4'hE, 1, 0, 0);
    add("s5_trail", 8, 1, 4'h5, 0, 0, 4'hF, 0,
        32'h00, 1, 4'hE, 4'hE, 1, 0, 0);
    post(4'h5);

    repeat (2) @(negedge clk);
    check("reset", {32'h0, 4'h0, 4'hF, 4'hF,
                    1'b0, 1'b0, 1'b0});
    resetb = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[j]) begin
      for (int r = 0; r < vq[j].reps; r++) begin
        drive(vq[j]);
        @(negedge clk);
        check(vq[j].name, vq[j].exp);
        @(posedge clk);
        #1;
      end
    end

    // reset while in ST_DATA
    num_active_lanes = 3'd1;
    md_polarity = '0;
    din = 32'h01;
    din_last = 1'b0;
    din_keep = '1;
    din_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!din_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (!din_ready) begin
      n_fail++;
      $display("FAIL rst_wait: ready %b want 1",
               din_ready);
    end
    repeat (2) @(negedge clk);
    check("rst_pre", {32'h01, 4'h1, 4'hE, 4'hE,
                      1'b1, 1'b1, 1'b0});
    resetb = 1'b0;
    #1;
    check("rst_async", {32'h0, 4'h0, 4'hF, 4'hF,
                        1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check("rst_edge", {32'h0, 4'h0, 4'hF, 4'hF,
                       1'b0, 1'b0, 1'b0});
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    check("restart", {32'h0, 4'h0, 4'hE, 4'hF,
                      1'b1, 1'b0, 1'b0});
    din_last = 1'b1;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (busy) begin
      n_fail++;
      $display("FAIL restart_done: busy %b want 0",
               busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
